// File: rtl/c1541_pkg.sv
// c1541_pkg: shared types and constants for the c1541 SD channel arbiter.
//   arb_state_t : arbiter state encoding (IDLE/REQ/XFER/DONE)
//   SD_LBA_W    : width of a sector address
//   DRV_IDX_W   : width of a drive index
//   BUFF_W      : width of a buffer data byte
//   rr_next()   : index reached by stepping 'step' places after 'cur', modulo ndrives
package c1541_pkg;

  localparam int SD_LBA_W  = 32;
  localparam int DRV_IDX_W = 2;
  localparam int BUFF_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  function automatic logic [DRV_IDX_W-1:0] rr_next(
    input logic [DRV_IDX_W-1:0] cur,
    input int unsigned          ndrives,
    input int unsigned          step
  );
    int unsigned sum;
    sum = 32'(cur) + step;
    return DRV_IDX_W'(sum % ndrives);
  endfunction

endpackage

// File: rtl/c1541_sd_arb_if.sv
// c1541_sd_arb_if: host-side SD block-transfer channel.
//   sd_lba      : sector address of the granted request
//   sd_rd/sd_wr : read / write request toward the host
//   sd_ack      : host transfer-active
//   sd_buff_wr  : host buffer write strobe
//   sd_buff_din : data of the granted drive toward the host
//   sd_drive    : index of the granted drive
// master = arbiter side, slave = host side.
interface c1541_sd_arb_if;
  import c1541_pkg::*;

  logic [SD_LBA_W-1:0]  sd_lba;
  logic                 sd_rd;
  logic                 sd_wr;
  logic                 sd_ack;
  logic                 sd_buff_wr;
  logic [BUFF_W-1:0]    sd_buff_din;
  logic [DRV_IDX_W-1:0] sd_drive;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, sd_drive,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, sd_drive,
    output sd_ack, sd_buff_wr
  );

endinterface

// File: rtl/c1541_rr_pick.sv
// c1541_rr_pick: combinational round-robin picker.
//   pending : one request bit per drive
//   last    : most recently completed drive; search starts one past it
//   valid   : some drive is pending
//   idx     : first pending drive found in rotated order
module c1541_rr_pick
  import c1541_pkg::*;
#(
  parameter int NDRIVES = 4
) (
  input  logic [NDRIVES-1:0]   pending,
  input  logic [DRV_IDX_W-1:0] last,
  output logic                 valid,
  output logic [DRV_IDX_W-1:0] idx
);

  // Walk from the farthest position back to last+1 so the nearest pending
  // drive is the one written last and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NDRIVES; k >= 1; k--) begin
      if (pending[rr_next(last, NDRIVES, k)]) begin
        valid = 1'b1;
        idx   = rr_next(last, NDRIVES, k);
      end
    end
  end

endmodule

// File: rtl/c1541_sd_arb.sv
// c1541_sd_arb: round-robin arbiter sharing one SD block-transfer channel
// among up to four drive track-buffer request ports.
//   clk_sys      : system clock, all state on the rising edge
//   reset        : synchronous, active-high
//   drv_lba      : per-drive LBA, drive i at [32*i+:32]
//   drv_rd/wr    : per-drive request levels
//   drv_ack      : per-drive gated copy of sd_ack
//   drv_buff_din : per-drive data toward SD, drive i at [8*i+:8]
//   drv_buff_wr  : per-drive gated copy of sd_buff_wr
//   sd           : host channel (master side)
//   busy         : arbiter is not in IDLE
module c1541_sd_arb
  import c1541_pkg::*;
#(
  parameter int NDRIVES = 4
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [NDRIVES*SD_LBA_W-1:0]  drv_lba,
  input  logic [NDRIVES-1:0]           drv_rd,
  input  logic [NDRIVES-1:0]           drv_wr,
  output logic [NDRIVES-1:0]           drv_ack,
  input  logic [NDRIVES*BUFF_W-1:0]    drv_buff_din,
  output logic [NDRIVES-1:0]           drv_buff_wr,
  c1541_sd_arb_if.master               sd,
  output logic                         busy
);

  arb_state_t           state_reg, state_next;
  logic [DRV_IDX_W-1:0] idx_reg, idx_next;
  logic [DRV_IDX_W-1:0] last_reg, last_next;
  logic [SD_LBA_W-1:0]  lba_reg, lba_next;
  logic                 rd_reg, rd_next;
  logic                 wr_reg, wr_next;

  logic [NDRIVES-1:0]   pending;
  logic                 pick_valid;
  logic [DRV_IDX_W-1:0] pick_idx;
  logic [SD_LBA_W-1:0]  pick_lba;
  logic                 pick_rd;
  logic                 granted_pending;
  logic                 active;
  logic [BUFF_W-1:0]    granted_din;

  assign pending = drv_rd | drv_wr;

  c1541_rr_pick #(.NDRIVES(NDRIVES)) u_pick (
    .pending (pending),
    .last    (last_reg),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // Select the picked drive's LBA/op and the granted drive's data and
  // request level with explicit compares, so no index can reach past NDRIVES.
  always_comb begin
    pick_lba        = '0;
    pick_rd         = 1'b0;
    granted_pending = 1'b0;
    granted_din     = '0;
    for (int i = 0; i < NDRIVES; i++) begin
      if (pick_idx == DRV_IDX_W'(i)) begin
        pick_lba = drv_lba[SD_LBA_W*i +: SD_LBA_W];
        pick_rd  = drv_rd[i];
      end
      if (idx_reg == DRV_IDX_W'(i)) begin
        granted_pending = pending[i];
        granted_din     = drv_buff_din[BUFF_W*i +: BUFF_W];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      last_reg  <= DRV_IDX_W'(NDRIVES-1);
      lba_reg   <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      lba_reg   <= lba_next;
      rd_reg    <= rd_next;
      wr_reg    <= wr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    lba_next   = lba_reg;
    rd_next    = rd_reg;
    wr_next    = wr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = REQ;
          idx_next   = pick_idx;
          lba_next   = pick_lba;
          // Read takes precedence when a drive raises both levels.
          rd_next    = pick_rd;
          wr_next    = !pick_rd;
        end
      end
      REQ: begin
        if (sd.sd_ack) begin
          rd_next    = 1'b0;
          wr_next    = 1'b0;
          state_next = XFER;
        end else if (!granted_pending) begin
          // Withdrawn before the host answered: no turn is consumed.
          rd_next    = 1'b0;
          wr_next    = 1'b0;
          state_next = IDLE;
        end
      end
      XFER: begin
        if (!sd.sd_ack) state_next = DONE;
      end
      DONE: begin
        if (!granted_pending) begin
          state_next = IDLE;
          last_next  = idx_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sd.sd_lba   = lba_reg;
  assign sd.sd_rd    = rd_reg;
  assign sd.sd_wr    = wr_reg;
  assign sd.sd_drive = idx_reg;
  assign busy        = (state_reg != IDLE);

  // Host strobes are steered only while a transfer is requested or running;
  // this path is combinational so drv_buff_wr lines up with the address/data
  // that fan out directly from the host.
  assign active         = (state_reg == REQ) || (state_reg == XFER);
  assign sd.sd_buff_din = active ? granted_din : '0;

  for (genvar gi = 0; gi < NDRIVES; gi++) begin : g_steer
    assign drv_ack[gi]     = active && sd.sd_ack     && (idx_reg == DRV_IDX_W'(gi));
    assign drv_buff_wr[gi] = active && sd.sd_buff_wr && (idx_reg == DRV_IDX_W'(gi));
  end

endmodule

// File: tb/tb_c1541_sd_arb.sv
// tb_c1541_sd_arb: randomized scoreboard bench for c1541_sd_arb.
// Stimulus computes the expected grant sequence from the round-robin rule and
// queues it; a negedge monitor pops and compares on every new host request.
module tb_c1541_sd_arb;
  import c1541_pkg::*;

  localparam int ND = 4;

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic [ND*32-1:0] drv_lba;
  logic [ND-1:0]    drv_rd  = '0;
  logic [ND-1:0]    drv_wr  = '0;
  logic [ND-1:0]    drv_ack;
  logic [ND*8-1:0]  drv_buff_din;
  logic [ND-1:0]    drv_buff_wr;
  logic             busy;

  logic [31:0] lba_m [ND];
  logic [7:0]  din_m [ND];

  c1541_sd_arb_if bus ();

  c1541_sd_arb #(.NDRIVES(ND)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .drv_buff_wr  (drv_buff_wr),
    .sd           (bus),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always_comb begin
    drv_lba      = '0;
    drv_buff_din = '0;
    for (int i = 0; i < ND; i++) begin
      drv_lba[32*i +: 32]    = lba_m[i];
      drv_buff_din[8*i +: 8] = din_m[i];
    end
  end

  typedef struct {
    int          drive;
    bit          rd;
    logic [31:0] lba;
  } exp_t;

  exp_t exp_q[$];
  int   compare_cnt = 0;
  int   fail_cnt    = 0;
  int   cur_drive   = 0;
  int   model_last  = ND - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    compare_cnt++;
    if (act !== expv) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    compare_cnt++;
    fail_cnt++;
    $display("FAIL %s: event did not occur (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  task automatic push_exp(input int d);
    exp_t e;
    e.drive = d;
    e.rd    = drv_rd[d];
    e.lba   = lba_m[d];
    exp_q.push_back(e);
    $display("expect grant: drive %0d %s lba %08h", d, e.rd ? "rd" : "wr", e.lba);
  endtask

  // All drives in mask are pending together and each is served to completion:
  // they are granted in rotated order starting one past the last served drive.
  task automatic push_round(input logic [ND-1:0] mask);
    int start;
    int lastd;
    start = model_last;
    lastd = model_last;
    for (int k = 1; k <= ND; k++) begin
      int d;
      d = (start + k) % ND;
      if (mask[d]) begin
        push_exp(d);
        lastd = d;
      end
    end
    model_last = lastd;
  endtask

  // op: 0 read, 1 write, 2 both
  task automatic set_req(input int d, input int op, input logic [31:0] lba, input logic [7:0] din);
    lba_m[d]  = lba;
    din_m[d]  = din;
    drv_rd[d] = (op != 1);
    drv_wr[d] = (op != 0);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    int n;
    n = 0;
    while (!(bus.sd_rd || bus.sd_wr) && n < 40) begin
      step();
      n++;
    end
    ok = bus.sd_rd || bus.sd_wr;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_last = ND - 1;
  endtask

  // Host model: answers one request, streams nstrobe buffer writes, then
  // ends the transfer and lets the granted drive withdraw.
  task automatic service(input int rereq, input int nstrobe);
    bit            ok;
    int            hits;
    logic [ND-1:0] oh;
    wait_grant(ok);
    if (!ok) begin
      fail_now("grant_timeout");
      return;
    end
    repeat ($urandom_range(0, 3)) step();
    bus.sd_ack = 1'b1;
    step();
    check("req_fall", {bus.sd_rd, bus.sd_wr}, 2'b00);
    oh = ND'(1) << cur_drive;
    check("ack_steer", drv_ack, oh);
    check("drive_hold", bus.sd_drive, cur_drive);
    if (rereq >= 0) drv_rd[rereq] = 1'b1;
    hits = 0;
    for (int s = 0; s < nstrobe; s++) begin
      bus.sd_buff_wr = 1'b1;
      #1;
      if (drv_buff_wr == oh) hits++;
      if (s < 2) check("din_steer", bus.sd_buff_din, din_m[cur_drive]);
      step();
      bus.sd_buff_wr = 1'b0;
      #1;
      if (drv_buff_wr != '0) hits--;
      step();
    end
    check("buff_wr_pulses", hits, nstrobe);
    bus.sd_ack = 1'b0;
    step();
    check("done_busy", busy, 1'b1);
    bus.sd_buff_wr = 1'b1;
    #1;
    check("done_ignore_wr", drv_buff_wr, '0);
    bus.sd_buff_wr = 1'b0;
    drv_rd[cur_drive] = 1'b0;
    drv_wr[cur_drive] = 1'b0;
    step();
    check("idle_after_done", busy, 1'b0);
    $display("served drive %0d, %0d strobes", cur_drive, nstrobe);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    bit   prev;
    bit   now;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      now = bus.sd_rd || bus.sd_wr;
      if (now && !prev) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          e = exp_q.pop_front();
          check("grant_drive", bus.sd_drive, e.drive);
          check("grant_op", {bus.sd_rd, bus.sd_wr}, e.rd ? 2'b10 : 2'b01);
          check("grant_lba", bus.sd_lba, e.lba);
          cur_drive = e.drive;
          $display("grant: drive %0d rd=%0b wr=%0b lba %08h", bus.sd_drive, bus.sd_rd, bus.sd_wr, bus.sd_lba);
        end
      end
      prev = now;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit ok;
    for (int i = 0; i < ND; i++) begin
      lba_m[i] = '0;
      din_m[i] = $urandom();
    end
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    apply_reset();

    // Reset values
    check("rst_sd_rd", bus.sd_rd, 1'b0);
    check("rst_sd_wr", bus.sd_wr, 1'b0);
    check("rst_sd_lba", bus.sd_lba, 32'h0);
    check("rst_sd_drive", bus.sd_drive, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_drv_ack", drv_ack, '0);
    check("rst_drv_buff_wr", drv_buff_wr, '0);

    // Spurious host activity in IDLE
    bus.sd_ack     = 1'b1;
    bus.sd_buff_wr = 1'b1;
    repeat (3) begin
      step();
      check("spur_ack", drv_ack, '0);
      check("spur_buff_wr", drv_buff_wr, '0);
      check("spur_busy", busy, 1'b0);
      check("spur_din", bus.sd_buff_din, 8'h00);
    end
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    step();

    // Abort before ack: last stays at 3, so {2,3} then resolves 2 first
    set_req(2, 0, $urandom(), $urandom());
    push_exp(2);
    wait_grant(ok);
    if (!ok) fail_now("abort_grant");
    drv_rd[2] = 1'b0;
    step();
    check("abort_rd", bus.sd_rd, 1'b0);
    check("abort_busy", busy, 1'b0);
    set_req(2, 0, $urandom(), $urandom());
    set_req(3, 0, $urandom(), $urandom());
    push_round(4'b1100);
    service(-1, 2);
    service(-1, 2);

    // Single read, drive 1, 512 strobes, one-cycle grant latency
    set_req(1, 0, 32'h123, $urandom());
    push_round(4'b0010);
    step();
    check("lat_rd", bus.sd_rd, 1'b1);
    check("lat_lba", bus.sd_lba, 32'h123);
    check("lat_drive", bus.sd_drive, 2'd1);
    service(-1, 512);

    // Contention after reset with a re-request from drive 0
    apply_reset();
    set_req(0, 0, $urandom(), $urandom());
    set_req(2, 0, $urandom(), $urandom());
    set_req(3, 0, $urandom(), $urandom());
    push_round(4'b1101);
    push_exp(0);
    model_last = 0;
    service(-1, 2);
    service(0, 2);
    service(-1, 2);
    service(-1, 2);

    // Write path and read-wins-over-write
    set_req(3, 1, $urandom(), 8'hA5);
    push_round(4'b1000);
    service(-1, 3);
    set_req(0, 2, $urandom(), $urandom());
    push_round(4'b0001);
    service(-1, 2);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      logic [ND-1:0] mask;
      mask = ND'($urandom_range(1, (1 << ND) - 1));
      for (int d = 0; d < ND; d++)
        if (mask[d]) set_req(d, $urandom_range(0, 2), $urandom(), $urandom());
      push_round(mask);
      for (int d = 0; d < ND; d++)
        if (mask[d]) service(-1, $urandom_range(1, 6));
    end

    // Reset during XFER with sd_ack still high
    set_req(1, 0, $urandom(), $urandom());
    push_exp(1);
    wait_grant(ok);
    if (!ok) fail_now("xfer_grant");
    bus.sd_ack = 1'b1;
    step();
    reset  = 1'b1;
    drv_rd = '0;
    drv_wr = '0;
    step();
    reset = 1'b0;
    check("rstx_rd", bus.sd_rd, 1'b0);
    check("rstx_wr", bus.sd_wr, 1'b0);
    check("rstx_busy", busy, 1'b0);
    check("rstx_ack", drv_ack, '0);
    check("rstx_lba", bus.sd_lba, 32'h0);
    step();
    check("rstx_ack_held", drv_ack, '0);
    bus.sd_ack = 1'b0;
    model_last = ND - 1;
    set_req(1, 0, $urandom(), $urandom());
    push_round(4'b0010);
    service(-1, 4);

    repeat (4) step();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/c1541_sd_arb.md
# c1541_sd_arb

Round-robin arbiter that lets up to four drive instances share one SD block-transfer channel. It sits between the per-drive track-buffer request ports (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) and the single host SD interface. It grants one sector transfer at a time and steers ack, write strobe and read-back data to the granted drive. All logic runs in the clk_sys domain.

## Interface
- NDRIVES, 4, number of drive request ports (1..4)
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- drv_lba  in  NDRIVES*32  per-drive LBA, drive i at [32*i+:32]
- drv_rd  in  NDRIVES  per-drive read request level
- drv_wr  in  NDRIVES  per-drive write request level
- drv_ack  out  NDRIVES  per-drive ack, gated copy of sd_ack
- drv_buff_din  in  NDRIVES*8  per-drive data toward SD, drive i at [8*i+:8]
- drv_buff_wr  out  NDRIVES  per-drive gated copy of sd_buff_wr
- sd_lba  out  32  LBA of granted request
- sd_rd  out  1  host read request
- sd_wr  out  1  host write request
- sd_ack  in  1  host transfer-active
- sd_buff_wr  in  1  host buffer write strobe
- sd_buff_din  out  8  data of granted drive toward host
- sd_drive  out  2  index of granted drive
- busy  out  1  high in any state other than IDLE
- sd_buff_addr and sd_buff_dout fan out directly to all drives. They do not pass through this block.

## Operation
- States: IDLE, REQ, XFER, DONE.
- IDLE
  - pending = drv_rd | drv_wr.
  - Pick the first pending index starting at last+1 mod NDRIVES.
  - On a pick: latch idx, lba = drv_lba[idx], and op = read if drv_rd[idx], else write. Read wins if both are set.
  - Then go to REQ.
- REQ
  - sd_rd = (op==read), sd_wr = (op==write), sd_lba = latched lba. All are registered.
  - On sd_ack=1: clear sd_rd/sd_wr and go to XFER.
  - If the granted drive drops both requests while sd_ack=0: clear sd_rd/sd_wr and go to IDLE, with last unchanged.
- XFER: on sd_ack=0, go to DONE.
- DONE: once drv_rd[idx]|drv_wr[idx] = 0, go to IDLE and set last = idx.
- Pass-through (combinational) while state is REQ or XFER:
  - drv_ack[i] = sd_ack & (i==idx)
  - drv_buff_wr[i] = sd_buff_wr & (i==idx)
  - sd_buff_din = drv_buff_din[idx]
- Outside REQ/XFER: all drv_ack and drv_buff_wr are 0, and sd_buff_din = 0.
- sd_ack or sd_buff_wr arriving in IDLE or DONE is ignored and not forwarded.
- Reset values: state IDLE; sd_rd=0, sd_wr=0, sd_lba=0, sd_drive=0, busy=0; last=NDRIVES-1, so drive 0 wins first; all drv_ack/drv_buff_wr=0.
- Reset mid-transfer returns to IDLE in one cycle. The host sees sd_rd/sd_wr fall. Any trailing sd_ack is ignored.
- Drive indices at or above NDRIVES do not exist; sd_drive never exceeds NDRIVES-1.

## Timing
- Request high at edge N while IDLE → sd_rd/sd_wr, sd_lba and sd_drive valid after edge N+1. Grant latency is 1 cycle.
- sd_ack → drv_ack has 0 cycles latency, so sd_buff_wr stays aligned with sd_buff_addr/sd_buff_dout.
- sd_rd/sd_wr fall on the edge after sd_ack is first sampled high.
- sd_ack fall → DONE on the next edge → IDLE no earlier than the following edge. Minimum gap between grants is 2 cycles after sd_ack falls.
- sd_lba and sd_drive hold stable from grant until the return to IDLE.

## Structure
- Shared package c1541_pkg:
  - state enum (IDLE/REQ/XFER/DONE)
  - SD_LBA_W = 32
  - DRV_IDX_W = 2
- Sub-module c1541_rr_pick:
  - inputs: pending[NDRIVES], last
  - outputs: valid, idx
  - purely combinational rotate-and-priority encode; instantiated once.

## Test plan
- Single read: drive 1 raises drv_rd with lba 0x123 → sd_rd=1, sd_lba=0x123, sd_drive=1 one cycle later. With 512 host writes, drv_buff_wr[1] pulses 512 times, other drives see 0, and drv_ack[1] mirrors sd_ack.
- Contention: drives 0, 2 and 3 request at the same edge after reset → grant order 0, 2, 3. Re-request by 0 during 2's transfer → order 0, 2, 3, 0.
- Write path: drive 3 drv_wr with drv_buff_din=0xA5 → sd_wr=1, and sd_buff_din=0xA5 during sd_ack. A drive with both rd and wr set → sd_rd only.
- Abort: drive 2 drops drv_rd while in REQ before ack → sd_rd falls the next cycle, state IDLE, and the next grant still starts the scan at drive 0.
- Spurious host: sd_ack/sd_buff_wr pulse in IDLE → all drv_ack/drv_buff_wr stay 0 and busy stays 0.
- Reset during XFER → the next cycle has sd_rd=sd_wr=0, busy=0, drv_ack=0 even with sd_ack still high; a new request afterward is granted normally.
